// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the debounced key-event outputs of keypad_scanner.
// The master side is whatever drives enable and the column returns.
interface keypad_scanner_if;
    logic       enable;
    logic [3:0] keypadCol;
    logic [3:0] keypadRow;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        output enable,
        output keypadCol,
        input  keypadRow,
        input  key_valid,
        input  key_code,
        input  key_held
    );

    modport slave (
        input  enable,
        input  keypadCol,
        output keypadRow,
        output key_valid,
        output key_code,
        output key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based debounce.
// Emits one key_valid pulse per accepted press with code {row, col}.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.slave  kp
);

    localparam int unsigned    DivW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]     CntTarget = 4'(DEBOUNCE_FRAMES);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StPressChk = 2'd1;
    localparam logic [1:0] StHeld     = 2'd2;
    localparam logic [1:0] StRelChk   = 2'd3;

    logic [3:0]      col_s1_q, col_s2_q;
    logic            active_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      row_q;
    logic [11:0]     slots_q;
    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d, cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      code_q, code_d;
    logic            held_q, held_d;
    logic            valid_q, valid_d;

    logic        sample, frame_end;
    logic [15:0] frame_bits;
    logic [4:0]  n_low;
    logic [3:0]  key_idx;
    logic        is_none, is_key;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q <= 4'b1111;
            col_s2_q <= 4'b1111;
        end else begin
            col_s1_q <= kp.keypadCol;
            col_s2_q <= col_s1_q;
        end
    end

    // active_q delays the first row by one cycle so every row gets a full SCAN_DIV window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            row_q    <= 2'd0;
        end else if (!kp.enable) begin
            active_q <= 1'b0;
            div_q    <= '0;
            row_q    <= 2'd0;
        end else begin
            active_q <= 1'b1;
            if (active_q) begin
                if (div_q == DivLast) begin
                    div_q <= '0;
                    row_q <= row_q + 2'd1;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    assign sample    = kp.enable && active_q && (div_q == DivLast);
    assign frame_end = sample && (row_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots_q <= 12'hfff;
        end else if (sample) begin
            case (row_q)
                2'd0:    slots_q[3:0]  <= col_s2_q;
                2'd1:    slots_q[7:4]  <= col_s2_q;
                2'd2:    slots_q[11:8] <= col_s2_q;
                default: ;
            endcase
        end
    end

    // Row 3 is classified straight from the synchronizer so the FSM acts on the sample edge.
    assign frame_bits = {col_s2_q, slots_q};

    always_comb begin
        n_low   = 5'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!frame_bits[i]) begin
                n_low   = n_low + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    assign is_none = (n_low == 5'd0);
    assign is_key  = (n_low == 5'd1);
    assign cnt_inc = (cnt_q >= CntTarget) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        held_d  = held_q;
        valid_d = 1'b0;
        if (!kp.enable) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            held_d  = 1'b0;
        end else if (frame_end) begin
            case (state_q)
                StIdle: begin
                    if (is_key) begin
                        cand_d = key_idx;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = StHeld;
                            valid_d = 1'b1;
                            code_d  = key_idx;
                            held_d  = 1'b1;
                        end else begin
                            state_d = StPressChk;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                StPressChk: begin
                    if (!is_key) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else if (key_idx != cand_q) begin
                        cand_d = key_idx;
                        cnt_d  = 4'd1;
                    end else if (cnt_inc >= CntTarget) begin
                        state_d = StHeld;
                        cnt_d   = cnt_inc;
                        valid_d = 1'b1;
                        code_d  = cand_q;
                        held_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHeld: begin
                    if (is_none) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = StIdle;
                            cnt_d   = 4'd0;
                            held_d  = 1'b0;
                        end else begin
                            state_d = StRelChk;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                default: begin
                    if (!is_none) begin
                        state_d = StHeld;
                    end else if (cnt_inc >= CntTarget) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                        held_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            held_q  <= held_d;
            valid_q <= valid_d;
        end
    end

    assign kp.keypadRow = active_q ? ~(4'b0001 << row_q) : 4'b0000;
    assign kp.key_valid = valid_q;
    assign kp.key_code  = code_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the columns, and a
// scoreboard queue of expected key codes is drained by a pulse monitor.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] pressed;
    logic        col_zero;
    int          checks;
    int          errors;
    logic [3:0]  exp_q[$];

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        kp.keypadCol = 4'b1111;
        if (col_zero) begin
            kp.keypadCol = 4'b0000;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (!kp.keypadRow[r] && pressed[r*4+c]) kp.keypadCol[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst && kp.key_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got code %h, expected no pulse", kp.key_code);
            end else begin
                e = exp_q.pop_front();
                if (kp.key_code !== e || kp.key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse_code: got code %h held %b, expected code %h held 1",
                             kp.key_code, kp.key_held, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Returns at the negedge just after the row-3 sample edge of each frame.
    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            int t;
            t = 0;
            while (kp.keypadRow != 4'b0111 && t < 100) begin
                @(negedge clk);
                t++;
            end
            while (kp.keypadRow == 4'b0111 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                checks++;
                errors++;
                $display("FAIL frame_timeout: got no frame boundary, expected one within 100 clks");
            end
        end
    endtask

    initial begin
        logic [3:0] exp_rows [4];
        int         t;
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        kp.enable = 1'b1;
        pressed  = 16'h0000;
        col_zero = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_row",   {12'h0, kp.keypadRow}, 16'h0000);
        check("reset_valid", {15'h0, kp.key_valid}, 16'h0000);
        check("reset_held",  {15'h0, kp.key_held},  16'h0000);
        check("reset_code",  {12'h0, kp.key_code},  16'h0000);

        col_zero = 1'b0;
        rst      = 1'b1;
        t = 0;
        while (kp.keypadRow != 4'b1110 && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 4; k++) begin
            check("row_step", {12'h0, kp.keypadRow}, {12'h0, exp_rows[k]});
            repeat (4) @(negedge clk);
        end

        // Clean press of (1,2).
        pressed = 16'h0040;
        exp_q.push_back(4'b0110);
        frames(1);
        check("press_no_early_pulse", {15'h0, kp.key_valid}, 16'h0000);
        frames(1);
        check("press_pulse", {15'h0, kp.key_valid}, 16'h0001);
        check("press_code",  {12'h0, kp.key_code},  16'h0006);
        frames(10);
        check("press_still_held", {15'h0, kp.key_held}, 16'h0001);
        pressed = 16'h0000;
        frames(2);
        check("press_released", {15'h0, kp.key_held}, 16'h0000);

        // Bounce on (3,1): present, absent, present, present.
        exp_q.push_back(4'b1101);
        pressed = 16'h2000;
        frames(1);
        pressed = 16'h0000;
        frames(1);
        pressed = 16'h2000;
        frames(1);
        check("bounce_no_early_pulse", {15'h0, kp.key_valid}, 16'h0000);
        frames(1);
        check("bounce_pulse", {15'h0, kp.key_valid}, 16'h0001);
        pressed = 16'h0000;
        frames(2);

        // Short release of (0,0) must not retrigger.
        exp_q.push_back(4'b0000);
        pressed = 16'h0001;
        frames(3);
        pressed = 16'h0000;
        frames(1);
        pressed = 16'h0001;
        frames(3);
        check("short_release_held", {15'h0, kp.key_held}, 16'h0001);
        pressed = 16'h0000;
        frames(2);
        check("full_release", {15'h0, kp.key_held}, 16'h0000);
        exp_q.push_back(4'b0000);
        pressed = 16'h0001;
        frames(2);
        check("repress_pulse", {15'h0, kp.key_valid}, 16'h0001);

        // Chord while held, then from idle.
        pressed = 16'h0801;
        frames(5);
        check("multi_while_held", {15'h0, kp.key_held}, 16'h0001);
        pressed = 16'h0000;
        frames(2);
        pressed = 16'h0801;
        frames(5);
        check("multi_from_idle", {15'h0, kp.key_held}, 16'h0000);
        pressed = 16'h0000;
        frames(1);

        // Enable drop while (2,1) is held, then re-enable with it still down.
        exp_q.push_back(4'b1001);
        pressed = 16'h0200;
        frames(2);
        check("en_pre_pulse", {15'h0, kp.key_valid}, 16'h0001);
        kp.enable = 1'b0;
        @(negedge clk);
        check("en_off_row",  {12'h0, kp.keypadRow}, 16'h0000);
        check("en_off_held", {15'h0, kp.key_held},  16'h0000);
        check("en_off_code", {12'h0, kp.key_code},  16'h0009);
        repeat (3) @(negedge clk);
        exp_q.push_back(4'b1001);
        kp.enable = 1'b1;
        frames(1);
        check("reen_no_early_pulse", {15'h0, kp.key_valid}, 16'h0000);
        frames(1);
        check("reen_pulse", {15'h0, kp.key_valid}, 16'h0001);

        repeat (5) @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and debounces it.
- Reports one clean key event per physical press as a one-cycle `key_valid` pulse with a 4-bit key code.
- Sits directly upstream of the hit-detection logic, which compares `key_code` against the mole position instead of decoding raw `keypadRow`/`keypadCol`.
- Runs on the system 50 MHz clock with an internal scan-tick divider.

Parameters:
- SCAN_DIV, 50000, clk cycles each row is driven before its columns are sampled (minimum 4).
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames needed to accept a press or a release (minimum 1, maximum 15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  scanning allowed (tied to the game-running flag)
- keypadCol  in  4  column returns, active-low, externally pulled up, asynchronous
- keypadRow  out  4  row drive, one row low at a time while scanning
- key_valid  out  1  one-cycle pulse when a debounced press is accepted
- key_code  out  4  {row[1:0], col[1:0]} of the last accepted key
- key_held  out  1  a debounced key is currently held

Behaviour:
- Reset (rst=0, asynchronous):
  - keypadRow=4'b0000, key_valid=0, key_code=0, key_held=0.
  - Row index=0, divider=0, candidate=none, debounce count=0, synchronizer flops=4'b1111.
- keypadCol passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Row drive while enabled: row r drives keypadRow with bit r low and all other bits high.
  - r=0 -> 4'b1110, r=1 -> 4'b1101, r=2 -> 4'b1011, r=3 -> 4'b0111.
- Divider counts 0..SCAN_DIV-1 for each row step.
  - On count SCAN_DIV-1, synchronized columns are sampled into a 4-bit row slot.
  - The row index then advances, wrapping 3->0.
- Frame: after the row-3 sample, the 16 sampled bits are classified:
  - NONE: no column low in any row.
  - KEY(r,c): exactly one low bit; c = index of the low keypadCol bit.
  - MULTI: two or more low bits (ghosting or chord).
- Debounce FSM is evaluated once per frame, in the clk cycle after the row-3 sample.
  - States: IDLE (nothing held), PRESS_CHK, HELD, RELEASE_CHK.
  - IDLE: KEY(k) -> candidate=k, count=1, go to PRESS_CHK. If DEBOUNCE_FRAMES=1, accept immediately instead.
  - PRESS_CHK, same KEY(k): count++. When count reaches DEBOUNCE_FRAMES -> accept and go to HELD.
  - PRESS_CHK, different KEY(j): candidate=j, count=1.
  - PRESS_CHK, NONE or MULTI: go to IDLE, count=0.
  - Accept: key_valid=1 for exactly that one clk cycle, key_code=candidate, key_held=1.
  - HELD, same key or MULTI: stay. MULTI never generates an event or a release.
  - HELD, NONE: count=1, go to RELEASE_CHK.
  - HELD, different KEY(j): stay HELD, no event; a new key must pass through release first.
  - RELEASE_CHK, NONE: count++. When count reaches DEBOUNCE_FRAMES -> key_held=0, go to IDLE.
  - RELEASE_CHK, any key: return to HELD, no new event.
- Count saturates at DEBOUNCE_FRAMES and never wraps.
- Latency:
  - The earliest key_valid is 1 clk after the row-3 sample of the DEBOUNCE_FRAMES-th matching frame.
  - key_code is stable from the key_valid cycle until the next accept.
- enable=0, checked synchronously every cycle, takes priority over the FSM:
  - keypadRow=4'b0000, divider and row index cleared, FSM forced to IDLE, key_held=0, key_valid=0.
  - key_code keeps its last value.
- Re-enable: scanning restarts at row 0 with divider 0, and a key already held must be fully debounced as a new press.
- enable falling in the same cycle as an accept: enable wins and no pulse is issued.
- rst asserted mid-frame: immediate return to the reset state; the partial frame is discarded.

Test Plan:
- Reset: rst=0 with keypadCol=4'b0000 -> keypadRow=4'b0000, key_valid=0, key_held=0, key_code=0. After release with enable=1, keypadRow steps 1110, 1101, 1011, 0111 every 4 clks (SCAN_DIV=4).
- Clean press: SCAN_DIV=4, DEBOUNCE_FRAMES=2; the model pulls keypadCol[2] low whenever keypadRow==4'b1101 -> exactly one key_valid pulse 1 clk after the end of the 2nd frame, key_code=4'b0110, key_held=1. No further pulses while held for 10 frames.
- Bounce: key (3,1) present in frame 1, absent in frame 2, present in frames 3-4 -> one pulse, at the end of frame 4, key_code=4'b1101.
- Release/re-press: hold (0,0) for 3 frames, release for 1 frame, press again for 3 frames -> one pulse only and key_held stays 1. Release for 2 frames, then press -> key_held=0 after release, then a second pulse.
- MULTI: keys (0,0) and (2,3) together for 5 frames from IDLE -> no pulse, key_held=0. Same chord while (0,0) is HELD -> key_held stays 1, no pulse.
- enable drop: enable=0 while HELD -> next clk keypadRow=4'b0000, key_held=0, key_code unchanged. Re-enable with the key still held -> new pulse after 2 frames.
